// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port VRAM arbiter for video fetch and CPU accesses, video priority
// with a bounded CPU starvation window. Define FB_ARB_POSTED_WR_EN for a one-entry posted CPU write buffer.
module fb_arbiter #(
  parameter int READ_LATENCY    = 1,
  parameter int MAX_VIDEO_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_m_access,
  input  logic [15:0] cpu_m_addr,
  input  logic        cpu_m_wr_en,
  input  logic [1:0]  cpu_m_bytesel,
  input  logic [15:0] cpu_m_data_in,
  output logic [15:0] cpu_m_data_out,
  output logic        cpu_m_ack,
  input  logic        fb_access,
  input  logic [15:0] fb_address,
  output logic [15:0] fb_data,
  output logic        fb_ack,
  output logic        vram_req,
  output logic        vram_we,
  output logic [15:0] vram_addr,
  output logic [1:0]  vram_be,
  output logic [15:0] vram_wdata,
  input  logic [15:0] vram_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_VID} tag_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_VIDEO_BURST);

  logic        r_cpu_busy;
  logic        r_vid_busy;
  logic [3:0]  r_vid_streak;
  tag_t        r_rd_tag;
  tag_t        r_tag [READ_LATENCY];
  logic        r_vram_req;
  logic        r_vram_we;
  logic [15:0] r_vram_addr;
  logic [1:0]  r_vram_be;
  logic [15:0] r_vram_wdata;
  logic        r_cpu_ack;
  logic [15:0] r_cpu_rdata;
  logic        r_fb_ack;
  logic [15:0] r_fb_rdata;

  logic        w_vid_elig;
  logic        w_cpu_elig;
  logic        w_grant_vid;
  logic        w_grant_cpu;
  logic        w_cpu_set_busy;
  logic        w_cpu_ack_nxt;
  logic        w_cpu_we;
  logic [15:0] w_cpu_addr;
  logic [1:0]  w_cpu_be;
  logic [15:0] w_cpu_wdata;
  logic [3:0]  w_streak_nxt;
  tag_t        w_tag_end;

  assign w_vid_elig = fb_access & ~r_vid_busy;
  assign w_tag_end  = r_tag[READ_LATENCY-1];

`ifdef FB_ARB_POSTED_WR_EN
  logic        r_wb_valid;
  logic [15:0] r_wb_addr;
  logic [15:0] r_wb_data;
  logic [1:0]  r_wb_be;
  logic        w_wb_accept;

  // A full buffer stands in for the CPU, so any new CPU access waits until it drains.
  assign w_wb_accept    = cpu_m_access & cpu_m_wr_en & ~r_cpu_busy & ~r_wb_valid;
  assign w_cpu_elig     = r_wb_valid | (cpu_m_access & ~cpu_m_wr_en & ~r_cpu_busy);
  assign w_cpu_we       = r_wb_valid;
  assign w_cpu_addr     = r_wb_valid ? r_wb_addr : cpu_m_addr;
  assign w_cpu_be       = r_wb_valid ? r_wb_be : cpu_m_bytesel;
  assign w_cpu_wdata    = r_wb_data;
  assign w_cpu_set_busy = w_wb_accept | (w_grant_cpu & ~r_wb_valid);
  assign w_cpu_ack_nxt  = w_wb_accept | (w_tag_end == TAG_CPU);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_wb_be    <= '0;
    end else if (w_wb_accept) begin
      r_wb_valid <= 1'b1;
      r_wb_addr  <= cpu_m_addr;
      r_wb_data  <= cpu_m_data_in;
      r_wb_be    <= cpu_m_bytesel;
    end else if (w_grant_cpu) begin
      r_wb_valid <= 1'b0;
    end
  end
`else
  assign w_cpu_elig     = cpu_m_access & ~r_cpu_busy;
  assign w_cpu_we       = cpu_m_wr_en;
  assign w_cpu_addr     = cpu_m_addr;
  assign w_cpu_be       = cpu_m_bytesel;
  assign w_cpu_wdata    = cpu_m_data_in;
  assign w_cpu_set_busy = w_grant_cpu;
  // Video never writes, so a write strobe on the port is always the CPU's.
  assign w_cpu_ack_nxt  = (r_vram_req & r_vram_we) | (w_tag_end == TAG_CPU);
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch, otherwise a latch is inferred.
    w_grant_vid  = 1'b0;
    w_grant_cpu  = 1'b0;
    w_streak_nxt = r_vid_streak;
    if (w_vid_elig && (!w_cpu_elig || (r_vid_streak < BURST_MAX))) begin
      w_grant_vid = 1'b1;
    end else if (w_cpu_elig) begin
      w_grant_cpu = 1'b1;
    end
    if (w_grant_cpu || !w_cpu_elig) begin
      w_streak_nxt = '0;
    end else if (w_grant_vid) begin
      w_streak_nxt = r_vid_streak + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_busy   <= 1'b0;
      r_vid_busy   <= 1'b0;
      r_vid_streak <= '0;
      r_rd_tag     <= TAG_NONE;
      // NOTE: the tag pipe is reset explicitly so reads in flight at reset are never acked.
      for (int i = 0; i < READ_LATENCY; i++) r_tag[i] <= TAG_NONE;
      r_vram_req   <= 1'b0;
      r_vram_we    <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_be    <= '0;
      r_vram_wdata <= '0;
      r_cpu_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_fb_ack     <= 1'b0;
      r_fb_rdata   <= '0;
    end else begin
      // NOTE: state updates are non-blocking so every register samples pre-edge values.
      r_vram_req <= w_grant_vid | w_grant_cpu;
      if (w_grant_vid) begin
        r_vram_we    <= 1'b0;
        r_vram_addr  <= fb_address;
        r_vram_be    <= 2'b11;
        r_vram_wdata <= '0;
        r_rd_tag     <= TAG_VID;
      end else if (w_grant_cpu) begin
        r_vram_we    <= w_cpu_we;
        r_vram_addr  <= w_cpu_addr;
        r_vram_be    <= w_cpu_be;
        r_vram_wdata <= w_cpu_wdata;
        r_rd_tag     <= w_cpu_we ? TAG_NONE : TAG_CPU;
      end else begin
        r_vram_we    <= 1'b0;
        r_vram_addr  <= '0;
        r_vram_be    <= '0;
        r_vram_wdata <= '0;
        r_rd_tag     <= TAG_NONE;
      end

      r_tag[0] <= r_rd_tag;
      for (int i = 1; i < READ_LATENCY; i++) r_tag[i] <= r_tag[i-1];

      r_cpu_ack <= w_cpu_ack_nxt;
      r_fb_ack  <= (w_tag_end == TAG_VID);
      if (w_tag_end == TAG_CPU) r_cpu_rdata <= vram_rdata;
      if (w_tag_end == TAG_VID) r_fb_rdata  <= vram_rdata;

      if (w_cpu_set_busy) r_cpu_busy <= 1'b1;
      else if (r_cpu_ack) r_cpu_busy <= 1'b0;
      if (w_grant_vid)    r_vid_busy <= 1'b1;
      else if (r_fb_ack)  r_vid_busy <= 1'b0;

      r_vid_streak <= w_streak_nxt;
    end
  end

  assign vram_req       = r_vram_req;
  assign vram_we        = r_vram_we;
  assign vram_addr      = r_vram_addr;
  assign vram_be        = r_vram_be;
  assign vram_wdata     = r_vram_wdata;
  assign cpu_m_ack      = r_cpu_ack;
  assign cpu_m_data_out = r_cpu_rdata;
  assign fb_ack         = r_fb_ack;
  assign fb_data        = r_fb_rdata;

endmodule
